// File: rtl/line_decoder_pkg.sv
// Shared definitions for the line scan decoder: FSM state encoding and the
// derivation of the output line count from the select width.
package line_decoder_pkg;

    // Controller states; exposed on the top-level debug port.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // Number of output lines addressed by an n-bit select.
    function automatic int line_count(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/line_decoder_core.sv
// Combinational one-hot decoder: sets line[sel] when enabled, otherwise all
// lines are off.
module line_decoder_core
    import line_decoder_pkg::*;
#(
    parameter  int N = 3,
    localparam int L = line_count(N)
) (
    input  logic         enable,
    input  logic [N-1:0] sel,
    output logic [L-1:0] lines
);

    // Decode sel into a single active line, gated by enable.
    always_comb begin
        lines = '0;
        if (enable) begin
            lines[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/line_scan_decoder.sv
// Line decoder with direct-select and auto-scan modes. In scan mode the
// active line starts at sel and advances every DWELL cycles, wrapping
// modulo L and pulsing wrap for the cycle in which index first reads 0.
// All outputs are registered; the current FSM state is exported on state.
module line_scan_decoder
    import line_decoder_pkg::*;
#(
    parameter  int N     = 3,
    parameter  int DWELL = 4,
    localparam int L     = line_count(N)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic         mode,
    input  logic [N-1:0] sel,
    input  logic         hold,
    output logic [L-1:0] f,
    output logic [N-1:0] index,
    output logic         wrap,
    output state_t       state
);

    // Smallest counter able to hold DWELL-1, never narrower than one bit.
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

    if (N < 1 || DWELL < 1) begin : g_bad_params
        $error("line_scan_decoder: N and DWELL must both be at least 1");
    end

    logic [CW-1:0] dwell_cnt;
    logic [N-1:0]  index_next;
    logic [N-1:0]  decode_sel;
    logic [L-1:0]  decoded;

    // Pick what the decoder sees: the next scan position while scanning,
    // otherwise the external select (direct mode and scan entry).
    always_comb begin
        index_next = index + 1'b1;
        decode_sel = sel;
        if (state == SCAN && mode) begin
            decode_sel = index_next;
        end
    end

    line_decoder_core #(.N(N)) u_core (
        .enable (enable),
        .sel    (decode_sel),
        .lines  (decoded)
    );

    // Controller FSM: enable/mode pick the state every cycle; scan state
    // tracks dwell and advances the active line with registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            f         <= '0;
            index     <= '0;
            wrap      <= 1'b0;
            dwell_cnt <= '0;
        end else if (!enable) begin
            state     <= IDLE;
            f         <= '0;
            index     <= '0;
            wrap      <= 1'b0;
            dwell_cnt <= '0;
        end else if (!mode) begin
            state     <= DIRECT;
            f         <= decoded;
            index     <= sel;
            wrap      <= 1'b0;
            dwell_cnt <= '0;
        end else if (state != SCAN) begin
            // Scan entry: start at sel with a fresh dwell period.
            state     <= SCAN;
            f         <= decoded;
            index     <= sel;
            wrap      <= 1'b0;
            dwell_cnt <= '0;
        end else if (hold) begin
            wrap <= 1'b0;
        end else if (dwell_cnt == DWELL_LAST) begin
            dwell_cnt <= '0;
            index     <= index_next;
            f         <= decoded;
            wrap      <= &index;
        end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
            wrap      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_line_scan_decoder.sv
// Bench for line_scan_decoder: one instance with DWELL=4 and one with DWELL=1
// share the same stimulus. A behavioural model tracks each instance by scan
// start point and elapsed active cycles; a negedge process compares both
// DUTs against it every cycle, and directed steps pin literal values.
module tb_line_scan_decoder;
    import line_decoder_pkg::*;

    localparam int N = 3;
    localparam int L = 8;
    localparam int DW [2] = '{4, 1};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         mode = 1'b0;
    logic [N-1:0] sel = '0;
    logic         hold = 1'b0;

    logic [L-1:0] f0, f1;
    logic [N-1:0] idx0, idx1;
    logic         wrap0, wrap1;
    state_t       st0, st1;

    int n_checks = 0;
    int n_fail = 0;
    bit checking = 1'b0;

    // Clock and reset block: 10-unit period; reset is driven by the stimulus.
    always #5 clk = ~clk;

    line_scan_decoder #(.N(N), .DWELL(4)) dut0 (
        .clock(clk), .reset(rst), .enable(en), .mode(mode), .sel(sel),
        .hold(hold), .f(f0), .index(idx0), .wrap(wrap0), .state(st0)
    );

    line_scan_decoder #(.N(N), .DWELL(1)) dut1 (
        .clock(clk), .reset(rst), .enable(en), .mode(mode), .sel(sel),
        .hold(hold), .f(f1), .index(idx1), .wrap(wrap1), .state(st1)
    );

    // Behavioural model: 0 = off, 1 = direct, 2 = scanning.
    int m_kind  [2] = '{0, 0};
    int m_dsel  [2] = '{0, 0};
    int m_start [2] = '{0, 0};
    int m_t     [2] = '{0, 0};
    bit m_wrap  [2] = '{1'b0, 1'b0};

    // Model update: scanning position is start + (active cycles / DWELL).
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst || !en) begin
                m_kind[k] <= 0;
                m_wrap[k] <= 1'b0;
            end else if (!mode) begin
                m_kind[k] <= 1;
                m_dsel[k] <= int'(sel);
                m_wrap[k] <= 1'b0;
            end else if (m_kind[k] != 2) begin
                m_kind[k]  <= 2;
                m_start[k] <= int'(sel);
                m_t[k]     <= 0;
                m_wrap[k]  <= 1'b0;
            end else if (hold) begin
                m_wrap[k] <= 1'b0;
            end else begin
                m_t[k]    <= m_t[k] + 1;
                m_wrap[k] <= ((m_t[k] + 1) % DW[k] == 0) &&
                             (((m_start[k] + (m_t[k] + 1) / DW[k]) % L) == 0);
            end
        end
    end

    function automatic void model_out(input int k, output logic [L-1:0] ef,
                                      output logic [N-1:0] ei, output logic ew);
        int pos;
        ef = '0;
        ei = '0;
        ew = 1'b0;
        if (m_kind[k] == 1) begin
            pos = m_dsel[k];
            ei  = N'(pos);
            ef  = L'(1) << pos;
        end else if (m_kind[k] == 2) begin
            pos = (m_start[k] + m_t[k] / DW[k]) % L;
            ei  = N'(pos);
            ef  = L'(1) << pos;
            ew  = m_wrap[k];
        end
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard compare: both DUTs against the model on every falling edge.
    always @(negedge clk) begin
        logic [L-1:0] ef;
        logic [N-1:0] ei;
        logic         ew;
        if (checking) begin
            model_out(0, ef, ei, ew);
            check("dw4_f", 32'(f0), 32'(ef));
            check("dw4_index", 32'(idx0), 32'(ei));
            check("dw4_wrap", 32'(wrap0), 32'(ew));
            model_out(1, ef, ei, ew);
            check("dw1_f", 32'(f1), 32'(ef));
            check("dw1_index", 32'(idx1), 32'(ei));
            check("dw1_wrap", 32'(wrap1), 32'(ew));
        end
    end

    // Driver: apply inputs, then step past the next rising edge.
    task automatic drive(input logic e, input logic m, input logic [N-1:0] s, input logic h);
        en   = e;
        mode = m;
        sel  = s;
        hold = h;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state.
        @(posedge clk);
        #1;
        check("reset_f", 32'(f0), 32'h0);
        check("reset_index", 32'(idx0), 32'h0);
        check("reset_wrap", 32'(wrap0), 32'h0);
        rst = 1'b0;
        checking = 1'b1;

        // Direct decode with one-edge latency, then a new select.
        drive(1, 0, 3'd5, 0);
        check("direct_sel5", 32'(f0), 32'h20);
        check("direct_idx5", 32'(idx0), 32'd5);
        drive(1, 0, 3'd2, 0);
        check("direct_sel2", 32'(f0), 32'h04);

        // Scan from 6: four cycles per line, wrap on reaching line 0.
        // Sel is moved during the scan and must be ignored.
        drive(1, 1, 3'd6, 0);
        check("scan6_c1", 32'(f0), 32'h40);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 3'd3, 0);
            check("scan6_dwell", 32'(f0), 32'h40);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 3'd1, 0);
            check("scan7_dwell", 32'(f0), 32'h80);
            check("scan7_nowrap", 32'(wrap0), 32'h0);
        end
        drive(1, 1, 3'd1, 0);
        check("scan_wrap_f", 32'(f0), 32'h01);
        check("scan_wrap_pulse", 32'(wrap0), 32'h1);
        drive(1, 1, 3'd1, 0);
        check("scan_wrap_once", 32'(wrap0), 32'h0);
        check("scan_wrap_f2", 32'(f0), 32'h01);

        // Hold at index 3 after one dwell cycle has elapsed.
        drive(1, 0, 3'd0, 0);
        drive(1, 1, 3'd3, 0);
        drive(1, 1, 3'd3, 0);
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 3'd3, 1);
            check("hold_f", 32'(f0), 32'h08);
            check("hold_wrap", 32'(wrap0), 32'h0);
        end
        drive(1, 1, 3'd3, 0);
        check("hold_resume1", 32'(f0), 32'h08);
        drive(1, 1, 3'd3, 0);
        check("hold_resume2", 32'(f0), 32'h08);
        drive(1, 1, 3'd3, 0);
        check("hold_advance", 32'(f0), 32'h10);
        check("hold_advance_idx", 32'(idx0), 32'd4);

        // Disable mid-scan, then restart the scan at line 1.
        drive(0, 1, 3'd3, 0);
        check("disable_f", 32'(f0), 32'h0);
        check("disable_idx", 32'(idx0), 32'h0);
        drive(1, 1, 3'd1, 0);
        check("restart_f", 32'(f0), 32'h02);
        check("restart_idx", 32'(idx0), 32'd1);

        // Asynchronous reset mid-scan takes effect before any edge.
        drive(1, 1, 3'd1, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_f", 32'(f0), 32'h0);
        check("async_rst_idx", 32'(idx0), 32'h0);
        check("async_rst_wrap", 32'(wrap0), 32'h0);
        check("async_rst_f_dw1", 32'(f1), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1, 1, 3'd4, 0);
        check("post_rst_scan", 32'(f0), 32'h10);

        // DWELL=1 instance: rotate one line per cycle, wrap every 8 cycles.
        drive(0, 0, 3'd0, 0);
        drive(1, 1, 3'd0, 0);
        check("dw1_start", 32'(f1), 32'h01);
        for (int k = 1; k <= 16; k++) begin
            logic [L-1:0] exp_f;
            exp_f = L'(1) << (k % 8);
            drive(1, 1, 3'd0, 0);
            check("dw1_rotate", 32'(f1), 32'(exp_f));
            check("dw1_wrap_period", 32'(wrap1), 32'((k % 8) == 0));
        end

        // Randomized traffic, with occasional resets, checked by the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 15) != 0, $urandom_range(0, 9) != 0,
                  N'($urandom_range(0, L - 1)), $urandom_range(0, 5) == 0);
        end
        rst = 1'b0;
        drive(1, 1, 3'd0, 0);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
